// File: rtl/datamemory_pkg.sv
// Shared definitions for the datamemory arbiter: default widths, bus-owner
// state encoding and requester identifiers.
package datamemory_pkg;

  localparam int DATA_SZ_DEF    = 32;
  localparam int ADDRESS_SZ_DEF = 10;
  localparam int MAX_WAIT_DEF   = 4;

  // Registered bus owner for the current cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_A = 1'b0;
  localparam port_id_t PORT_B = 1'b1;

  // Bits needed to count 0..max_wait inclusive (at least one bit).
  function automatic int wait_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/datamemory_arb_core.sv
// Winner select between the two masked requesters plus the starvation
// counter that lets the low-priority port B override port A.
module datamemory_arb_core
  import datamemory_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = wait_width(MAX_WAIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_m,
  input  logic              b_req_m,
  input  logic              b_req,
  output logic              win_valid,
  output port_id_t          win_port,
  output logic [WAIT_W-1:0] b_wait
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic b_won;
  logic b_lost;

  // A has priority unless B has already lost MAX_WAIT cycles in a row.
  always_comb begin
    win_valid = a_req_m | b_req_m;
    win_port  = PORT_A;
    if (b_req_m && (!a_req_m || (b_wait == WAIT_MAX))) begin
      win_port = PORT_B;
    end
    b_won  = win_valid && (win_port == PORT_B);
    b_lost = b_req_m && !b_won;
  end

  // Saturating count of consecutive cycles B competed and lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_wait <= '0;
    end else if (!b_req || b_won) begin
      b_wait <= '0;
    end else if (b_lost && (b_wait != WAIT_MAX)) begin
      b_wait <= b_wait + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/datamemory_arbiter.sv
// Shares one single-port data memory between a high-priority CPU port (A)
// and a low-priority DMA/debug port (B). One access per cycle, read data
// returned to the issuing port two cycles after its request is sampled.
module datamemory_arbiter
  import datamemory_pkg::*;
#(
  parameter int DATA_SZ    = DATA_SZ_DEF,
  parameter int ADDRESS_SZ = ADDRESS_SZ_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDRESS_SZ-1:0] a_addr,
  input  logic [DATA_SZ-1:0]    a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_SZ-1:0]    a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDRESS_SZ-1:0] b_addr,
  input  logic [DATA_SZ-1:0]    b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_SZ-1:0]    b_rdata,
  output logic [ADDRESS_SZ-1:0] mem_address,
  output logic [DATA_SZ-1:0]    mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_SZ-1:0]    mem_data_out
);

  localparam int WAIT_W = wait_width(MAX_WAIT);

  state_t             state;
  logic               a_req_m;
  logic               b_req_m;
  logic               win_valid;
  port_id_t           win_port;
  logic [WAIT_W-1:0]  b_wait;
  logic               rd_a;
  logic               rd_b;
  logic [DATA_SZ-1:0] rdata_a_q;
  logic [DATA_SZ-1:0] rdata_b_q;

  // A port that owns the bus this cycle is still holding the request that
  // was just granted, so it is hidden from arbitration for this cycle.
  assign a_req_m = a_req && (state != ISSUE_A);
  assign b_req_m = b_req && (state != ISSUE_B);

  datamemory_arb_core #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .a_req_m   (a_req_m),
    .b_req_m   (b_req_m),
    .b_req     (b_req),
    .win_valid (win_valid),
    .win_port  (win_port),
    .b_wait    (b_wait)
  );

  // Bus-owner FSM: latch the winner's request onto the memory bus and
  // record whether the issued access is a read that needs data returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      rd_a        <= 1'b0;
      rd_b        <= 1'b0;
    end else begin
      state  <= IDLE;
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      mem_we <= 1'b0;
      rd_a   <= 1'b0;
      rd_b   <= 1'b0;
      if (win_valid) begin
        if (win_port == PORT_A) begin
          state       <= ISSUE_A;
          a_gnt       <= 1'b1;
          mem_address <= a_addr;
          mem_data_in <= a_wdata;
          mem_we      <= a_we;
          rd_a        <= !a_we;
        end else begin
          state       <= ISSUE_B;
          b_gnt       <= 1'b1;
          mem_address <= b_addr;
          mem_data_in <= b_wdata;
          mem_we      <= b_we;
          rd_b        <= !b_we;
        end
      end
    end
  end

  // Return path: read flag delayed one cycle to line up with the memory's
  // output, and the last returned word kept for each port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      a_rvalid <= rd_a;
      b_rvalid <= rd_b;
      if (a_rvalid) begin
        rdata_a_q <= mem_data_out;
      end
      if (b_rvalid) begin
        rdata_b_q <= mem_data_out;
      end
    end
  end

  // The memory output is already registered inside the memory, so during
  // the rvalid cycle it is forwarded directly; afterwards the held copy
  // keeps rdata stable until that port's next rvalid.
  assign a_rdata = a_rvalid ? mem_data_out : rdata_a_q;
  assign b_rdata = b_rvalid ? mem_data_out : rdata_b_q;

endmodule

// File: tb/tb_datamemory_arbiter.sv
module tb_datamemory_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MAX_WAIT = 4;

  logic          clk;
  logic          rst;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_we;

  int vectors = 0;
  int miscompares = 0;

  datamemory_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Synchronous-read single-port memory; contents reload while in reset.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_address] <= mem_data_in;
    end
    mem_data_out <= mem[mem_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] a_q [$];
  logic [DW-1:0] b_q [$];
  logic          m_gnt_a, m_gnt_b, m_rv_a, m_rv_b, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, last_a, last_b, exp_d;
  int            m_bwait;
  int            a_rv_total = 0, b_rv_total = 0, b_gnt_total = 0;
  int            cur_run = 0, last_run = 0;

  initial begin : monitor
    logic am, bm, wa, wb;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_ctrl", 64'({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we}), 64'd0);
        chk("reset_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        chk("reset_membus", 64'({mem_address, mem_data_in}), 64'd0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        a_q.delete(); b_q.delete();
        m_gnt_a = 0; m_gnt_b = 0; m_rv_a = 0; m_rv_b = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; last_a = '0; last_b = '0; m_bwait = 0;
      end else begin
        chk("a_gnt", 64'(a_gnt), 64'(m_gnt_a));
        chk("b_gnt", 64'(b_gnt), 64'(m_gnt_b));
        chk("a_rvalid", 64'(a_rvalid), 64'(m_rv_a));
        chk("b_rvalid", 64'(b_rvalid), 64'(m_rv_b));
        chk("rvalid_exclusive", 64'(a_rvalid & b_rvalid), 64'd0);
        chk("b_wait", 64'(dut.b_wait), 64'(m_bwait));
        if (m_gnt_a || m_gnt_b) begin
          chk("mem_address", 64'(mem_address), 64'(m_addr));
          chk("mem_we", 64'(mem_we), 64'(m_we));
          if (m_we) chk("mem_data_in", 64'(mem_data_in), 64'(m_wdata));
        end else begin
          chk("mem_we_idle", 64'(mem_we), 64'd0);
        end
        if (a_rvalid && a_q.size() > 0) begin
          exp_d = a_q.pop_front();
          chk("a_rdata", 64'(a_rdata), 64'(exp_d));
          last_a = exp_d;
        end else begin
          chk("a_rdata_hold", 64'(a_rdata), 64'(last_a));
        end
        if (b_rvalid && b_q.size() > 0) begin
          exp_d = b_q.pop_front();
          chk("b_rdata", 64'(b_rdata), 64'(exp_d));
          last_b = exp_d;
        end else begin
          chk("b_rdata_hold", 64'(b_rdata), 64'(last_b));
        end
        if (a_rvalid) a_rv_total++;
        if (b_rvalid) b_rv_total++;
        if (b_gnt) b_gnt_total++;
        if (a_gnt || b_gnt) cur_run++;
        else if (cur_run > 0) begin last_run = cur_run; cur_run = 0; end

        // Next cycle: the access issued now returns data if it is a read.
        m_rv_a = m_gnt_a && !m_we;
        m_rv_b = m_gnt_b && !m_we;
        // Arbitration: a port that is being served ignores its held request.
        am = a_req && !m_gnt_a;
        bm = b_req && !m_gnt_b;
        wb = bm && (!am || m_bwait == MAX_WAIT);
        wa = am && !wb;
        if (!b_req || wb) m_bwait = 0;
        else if (bm && m_bwait < MAX_WAIT) m_bwait++;
        m_we = 1'b0;
        if (wa) begin
          m_addr = a_addr; m_we = a_we; m_wdata = a_wdata;
          if (a_we) ref_mem[a_addr] = a_wdata; else a_q.push_back(ref_mem[a_addr]);
        end else if (wb) begin
          m_addr = b_addr; m_we = b_we; m_wdata = b_wdata;
          if (b_we) ref_mem[b_addr] = b_wdata; else b_q.push_back(ref_mem[b_addr]);
        end
        m_gnt_a = wa;
        m_gnt_b = wb;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic a_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      output int waits);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; waits = 0;
    do begin @(negedge clk); waits++; end while (!a_gnt && waits < 40);
    chk("a_gnt_seen", 64'(a_gnt), 64'd1);
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0;
  endtask

  task automatic b_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      output int waits);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; waits = 0;
    do begin @(negedge clk); waits++; end while (!b_gnt && waits < 40);
    chk("b_gnt_seen", 64'(b_gnt), 64'd1);
    @(posedge clk); #1;
    b_req = 1'b0; b_we = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w, wa_s, wb_s, wa_r, wb_r, snap0, snap1;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a read: the read must never come back.
    snap0 = a_rv_total;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd3;
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_drops_read", 64'(a_rv_total - snap0), 64'd0);

    // Port A alone: writes then reads back, two-cycle grant spacing.
    for (int i = 0; i < 5; i++) begin
      a_op(1'b1, 10'(i), 32'(2 * i), w);
      chk("a_wr_latency", 64'(w), 64'd2);
    end
    for (int i = 0; i < 5; i++) begin
      a_op(1'b0, 10'(i), '0, w);
      chk("a_rd_latency", 64'(w), 64'd2);
    end
    @(negedge clk);
    chk("a_last_read_is_8", 64'(a_rdata), 64'd8);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Simultaneous A read / B write of the same address.
    fork
      a_op(1'b0, 10'd1, '0, wa_s);
      b_op(1'b1, 10'd1, 32'h55, wb_s);
    join
    chk("sim_a_latency", 64'(wa_s), 64'd2);
    chk("sim_b_latency", 64'(wb_s), 64'd3);
    @(negedge clk);
    chk("sim_a_old_value", 64'(a_rdata), 64'd2);
    @(posedge clk); #1;
    a_op(1'b0, 10'd1, '0, w);
    @(negedge clk);
    chk("a_sees_b_write", 64'(a_rdata), 64'h55);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // A hammering addr 7 while B reads addr 9.
    fork
      begin
        for (int k = 0; k < 8; k++) a_op(1'b0, 10'd7, '0, wa_r);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        b_op(1'b0, 10'd9, '0, wb_r);
        chk("b_starve_bound", 64'(wb_r <= MAX_WAIT + 2), 64'd1);
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    chk("b_wait_after_starve", 64'(dut.b_wait), 64'd0);

    // Interleaved read streams: bus busy every cycle for 8 cycles.
    fork
      begin for (int k = 0; k < 4; k++) a_op(1'b0, 10'(k), '0, wa_r); end
      begin for (int k = 0; k < 4; k++) b_op(1'b0, 10'(k), '0, wb_r); end
    join
    @(negedge clk); #1;
    chk("interleave_busy_run", 64'(last_run), 64'd8);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // B withdraws after losing one cycle to A.
    snap0 = b_gnt_total;
    snap1 = b_rv_total;
    fork
      a_op(1'b0, 10'd5, '0, w);
      begin
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'd6;
        @(posedge clk); #1;
        b_req = 1'b0;
      end
    join
    repeat (4) begin @(posedge clk); #1; end
    chk("withdraw_no_b_gnt", 64'(b_gnt_total - snap0), 64'd0);
    chk("withdraw_no_b_rvalid", 64'(b_rv_total - snap1), 64'd0);
    chk("withdraw_b_wait", 64'(dut.b_wait), 64'd0);

    // Randomized traffic on both ports over a small address window.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          a_op(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, wa_r);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          b_op(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, wb_r);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (6) begin @(posedge clk); #1; end
    chk("a_queue_drained", 64'(a_q.size()), 64'd0);
    chk("b_queue_drained", 64'(b_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
